// File: rtl/instr_fetch_if.sv
// Instruction memory read channel between the fetch unit and instruction memory.
// The master side issues the read; the slave side returns data with a ready strobe.
interface instr_fetch_if;
   logic        mem_rd;
   logic [63:0] mem_addr;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (
      output mem_rd,
      output mem_addr,
      input  mem_rdata,
      input  mem_ready
   );

   modport slave (
      input  mem_rd,
      input  mem_addr,
      output mem_rdata,
      output mem_ready
   );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch unit: holds the PC, reads one instruction word per request,
// presents it to decode until consumed, and faults sticky on memory timeout.
module instr_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned TIMEOUT  = 15
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 pc_load,
   input  logic [63:0]          pc_in,
   input  logic                 consume,
   instr_fetch_if.master        mem,
   output logic [63:0]          pc,
   output logic [31:0]          instr,
   output logic [6:0]           ir6_0,
   output logic                 ir_valid,
   output logic                 fetch_err
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] FETCH = 2'd1;
   localparam logic [1:0] HOLD  = 2'd2;
   localparam logic [1:0] ERROR = 2'd3;

   localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

   // Branch targets are word aligned; the low two address bits are discarded.
   function automatic logic [63:0] align_word(input logic [63:0] addr);
      return addr & ~64'd3;
   endfunction

   logic [1:0]  state_r;
   logic [1:0]  state_nxt_s;
   logic [63:0] pc_r;
   logic [63:0] pc_nxt_s;
   logic [7:0]  wait_cnt_r;
   logic [7:0]  wait_cnt_nxt_s;
   logic        capture_s;
   logic [31:0] instr_r;
   logic [6:0]  ir6_0_r;
   logic        mem_rd_r;
   logic        ir_valid_r;
   logic        fetch_err_r;

   // Next-state, PC and wait-counter selection.
   always_comb begin
      state_nxt_s    = state_r;
      pc_nxt_s       = pc_r;
      wait_cnt_nxt_s = wait_cnt_r;
      capture_s      = 1'b0;
      case (state_r)
         IDLE: begin
            if (pc_load) begin
               pc_nxt_s = align_word(pc_in);
            end else begin
               pc_nxt_s = pc_r;
            end
            if (start) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         FETCH: begin
            // Data arriving on the last permitted wait cycle still wins over the fault.
            if (mem.mem_ready) begin
               capture_s      = 1'b1;
               wait_cnt_nxt_s = 8'd0;
               state_nxt_s    = HOLD;
            end else if (wait_cnt_r == WAIT_LAST) begin
               state_nxt_s    = ERROR;
            end else begin
               wait_cnt_nxt_s = wait_cnt_r + 8'd1;
            end
         end
         HOLD: begin
            if (pc_load) begin
               pc_nxt_s = align_word(pc_in);
            end else if (consume) begin
               pc_nxt_s = pc_r + 64'd4;
            end else begin
               pc_nxt_s = pc_r;
            end
            if (consume) begin
               state_nxt_s = FETCH;
            end else begin
               state_nxt_s = HOLD;
            end
         end
         ERROR: begin
            state_nxt_s = ERROR;
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // State, PC, instruction register and registered status outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_r     <= IDLE;
         pc_r        <= RESET_PC;
         wait_cnt_r  <= 8'd0;
         instr_r     <= 32'd0;
         ir6_0_r     <= 7'd0;
         mem_rd_r    <= 1'b0;
         ir_valid_r  <= 1'b0;
         fetch_err_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         pc_r        <= pc_nxt_s;
         wait_cnt_r  <= wait_cnt_nxt_s;
         if (capture_s) begin
            instr_r <= mem.mem_rdata;
            ir6_0_r <= mem.mem_rdata[6:0];
         end
         mem_rd_r    <= (state_nxt_s == FETCH);
         ir_valid_r  <= (state_nxt_s == HOLD);
         fetch_err_r <= (state_nxt_s == ERROR);
      end
   end

   assign mem.mem_rd   = mem_rd_r;
   assign mem.mem_addr = pc_r;
   assign pc           = pc_r;
   assign instr        = instr_r;
   assign ir6_0        = ir6_0_r;
   assign ir_valid     = ir_valid_r;
   assign fetch_err    = fetch_err_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: expected instructions are queued by the stimulus
// and checked by a monitor each time a new instruction becomes valid.
module tb_instr_fetch;
   logic        clk;
   logic        reset;
   logic        start;
   logic        pc_load;
   logic [63:0] pc_in;
   logic        consume;
   logic [63:0] pc;
   logic [31:0] instr;
   logic [6:0]  ir6_0;
   logic        ir_valid;
   logic        fetch_err;

   instr_fetch_if bus ();

   instr_fetch #(.RESET_PC(64'h0), .TIMEOUT(15)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .pc_load   (pc_load),
      .pc_in     (pc_in),
      .consume   (consume),
      .mem       (bus),
      .pc        (pc),
      .instr     (instr),
      .ir6_0     (ir6_0),
      .ir_valid  (ir_valid),
      .fetch_err (fetch_err)
   );

   typedef struct {
      logic [31:0] instr;
      logic [6:0]  op;
      logic [63:0] pc;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push_exp(input logic [31:0] i, input logic [6:0] op, input logic [63:0] p);
      exp_t e;
      e.instr = i;
      e.op    = op;
      e.pc    = p;
      exp_q.push_back(e);
   endtask

   // Monitor: compare each newly presented instruction against the scoreboard.
   logic prev_valid = 1'b0;
   always @(negedge clk) begin
      if (ir_valid && !prev_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL mon_unexpected: got instr %h with no expected entry", instr);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mon_instr", {32'd0, instr}, {32'd0, e.instr});
            chk("mon_ir6_0", {57'd0, ir6_0}, {57'd0, e.op});
            chk("mon_pc", pc, e.pc);
         end
      end
      prev_valid <= ir_valid;
   end

   initial begin
      reset = 1'b0; start = 1'b0; pc_load = 1'b0; pc_in = 64'd0; consume = 1'b0;
      bus.mem_ready = 1'b0; bus.mem_rdata = 32'd0;
      tick(2);
      chk("rst_pc", pc, 64'd0);
      chk("rst_mem_rd", {63'd0, bus.mem_rd}, 64'd0);
      chk("rst_ir_valid", {63'd0, ir_valid}, 64'd0);
      chk("rst_fetch_err", {63'd0, fetch_err}, 64'd0);
      chk("rst_instr", {32'd0, instr}, 64'd0);

      // First cycle after reset release accepts start; ready on first FETCH cycle.
      reset = 1'b1; start = 1'b1;
      tick();
      start = 1'b0;
      chk("fetch0_mem_rd", {63'd0, bus.mem_rd}, 64'd1);
      chk("fetch0_addr", bus.mem_addr, 64'd0);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00A00093;
      push_exp(32'h00A00093, 7'd19, 64'd0);
      tick();
      bus.mem_ready = 1'b0;
      chk("hold0_valid", {63'd0, ir_valid}, 64'd1);
      chk("hold0_mem_rd", {63'd0, bus.mem_rd}, 64'd0);

      // Consume, then three wait cycles before data.
      consume = 1'b1;
      tick();
      consume = 1'b0;
      chk("fetch1_pc", pc, 64'd4);
      chk("fetch1_mem_rd", {63'd0, bus.mem_rd}, 64'd1);
      chk("fetch1_valid", {63'd0, ir_valid}, 64'd0);
      tick(3);
      chk("fetch1_wait_mem_rd", {63'd0, bus.mem_rd}, 64'd1);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h123450B7;
      push_exp(32'h123450B7, 7'd55, 64'd4);
      tick();
      bus.mem_ready = 1'b0;
      chk("hold1_valid", {63'd0, ir_valid}, 64'd1);

      // Load in HOLD without consume: PC changes, instruction kept.
      pc_load = 1'b1; pc_in = 64'h203;
      tick();
      pc_load = 1'b0;
      chk("hold_load_pc", pc, 64'h200);
      chk("hold_load_instr", {32'd0, instr}, 64'h123450B7);
      chk("hold_load_valid", {63'd0, ir_valid}, 64'd1);

      // Consume with load: loaded target wins over pc+4.
      consume = 1'b1; pc_load = 1'b1; pc_in = 64'h103;
      tick();
      consume = 1'b0;
      chk("jump_pc", pc, 64'h100);
      chk("jump_addr", bus.mem_addr, 64'h100);
      pc_in = 64'h500;
      tick();
      pc_load = 1'b0;
      chk("fetch_ignores_load", pc, 64'h100);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00000013;
      push_exp(32'h00000013, 7'd19, 64'h100);
      tick();
      bus.mem_ready = 1'b0;

      // PC wrap at the top of the address space.
      pc_load = 1'b1; pc_in = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      pc_load = 1'b0;
      consume = 1'b1;
      tick();
      consume = 1'b0;
      chk("wrap_pc", pc, 64'd0);
      chk("wrap_mem_rd", {63'd0, bus.mem_rd}, 64'd1);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFFFFFF;
      push_exp(32'hFFFFFFFF, 7'h7F, 64'd0);
      tick();
      bus.mem_ready = 1'b0;

      // Reset in the middle of a fetch discards pending data.
      consume = 1'b1;
      tick();
      consume = 1'b0;
      reset = 1'b0; bus.mem_ready = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
      tick();
      bus.mem_ready = 1'b0; reset = 1'b1;
      chk("midrst_mem_rd", {63'd0, bus.mem_rd}, 64'd0);
      chk("midrst_instr", {32'd0, instr}, 64'd0);
      chk("midrst_valid", {63'd0, ir_valid}, 64'd0);
      chk("midrst_pc", pc, 64'd0);

      // Data on the last allowed wait cycle is still captured.
      start = 1'b1;
      tick();
      start = 1'b0;
      tick(14);
      chk("late_no_err", {63'd0, fetch_err}, 64'd0);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
      push_exp(32'hDEADBEEF, 7'h6F, 64'd0);
      tick();
      bus.mem_ready = 1'b0;
      chk("late_valid", {63'd0, ir_valid}, 64'd1);
      chk("late_no_err2", {63'd0, fetch_err}, 64'd0);

      // Full timeout: fault after 15 idle wait cycles, then sticky.
      consume = 1'b1;
      tick();
      consume = 1'b0;
      tick(14);
      chk("tmo_before", {63'd0, fetch_err}, 64'd0);
      tick();
      chk("tmo_err", {63'd0, fetch_err}, 64'd1);
      chk("tmo_mem_rd", {63'd0, bus.mem_rd}, 64'd0);
      chk("tmo_valid", {63'd0, ir_valid}, 64'd0);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h11111111;
      start = 1'b1; consume = 1'b1; pc_load = 1'b1; pc_in = 64'h80;
      tick(2);
      chk("err_sticky", {63'd0, fetch_err}, 64'd1);
      chk("err_pc", pc, 64'd4);
      chk("err_valid", {63'd0, ir_valid}, 64'd0);
      bus.mem_ready = 1'b0; start = 1'b0; consume = 1'b0; pc_load = 1'b0;
      reset = 1'b0;
      tick();
      chk("err_rst_clear", {63'd0, fetch_err}, 64'd0);
      chk("err_rst_pc", pc, 64'd0);

      // Load and start together in IDLE: fetch uses the new PC.
      reset = 1'b1; pc_load = 1'b1; pc_in = 64'h41; start = 1'b1;
      tick();
      pc_load = 1'b0; start = 1'b0;
      chk("idle_load_pc", pc, 64'h40);
      chk("idle_load_addr", bus.mem_addr, 64'h40);
      chk("idle_load_mem_rd", {63'd0, bus.mem_rd}, 64'd1);
      bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00000093;
      push_exp(32'h00000093, 7'd19, 64'h40);
      tick();
      bus.mem_ready = 1'b0;
      tick(2);

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded at reset.
REQ-002 Parameter TIMEOUT, default 15, max cycles FETCH waits for mem_ready before faulting; legal range 2..255.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
REQ-005 start  input  1  begin fetching from current PC; sampled in IDLE only.
REQ-006 pc_load  input  1  load pc_in into PC (branch/jump target).
REQ-007 pc_in  input  64  new PC value.
REQ-008 consume  input  1  downstream (decode / sign-extend stage) accepts held instruction.
REQ-009 mem_rdata  input  32  instruction memory read data.
REQ-010 mem_ready  input  1  mem_rdata valid this cycle.
REQ-011 mem_rd  output  1  instruction memory read request.
REQ-012 mem_addr  output  64  read address, equals pc.
REQ-013 pc  output  64  current program counter.
REQ-014 instr  output  32  instruction register; feeds sign-extend stage entrada.
REQ-015 ir6_0  output  7  instr[6:0] opcode field; feeds sign-extend stage IR6_0.
REQ-016 ir_valid  output  1  instr holds a fetched instruction not yet consumed.
REQ-017 fetch_err  output  1  fetch timed out; sticky until reset.

Function
REQ-018 FSM states SHALL be IDLE, FETCH, HOLD, ERROR.
REQ-019 IDLE: mem_rd=0, ir_valid=0; start=1 -> FETCH next cycle.
REQ-020 FETCH: mem_rd=1, mem_addr=pc, wait counter increments each cycle mem_ready=0.
REQ-021 FETCH with mem_ready=1: instr<=mem_rdata, counter<=0, -> HOLD; ready on first FETCH cycle gives ir_valid in cycle after (latency 1 from ready).
REQ-022 FETCH: counter reaching TIMEOUT-1 with mem_ready=0 -> ERROR; mem_ready=1 in that same cycle takes priority (captured, -> HOLD).
REQ-023 HOLD: ir_valid=1, mem_rd=0, instr and ir6_0 stable.
REQ-024 HOLD with consume=1: pc<=pc+4 (mod 2^64, wraps FFFF_FFFF_FFFF_FFFC -> 0), -> FETCH.
REQ-025 HOLD with consume=1 and pc_load=1: pc<=pc_in (pc_in wins over pc+4), -> FETCH.
REQ-026 HOLD with pc_load=1, consume=0: pc<=pc_in, remain HOLD, instr unchanged.
REQ-027 IDLE with pc_load=1: pc<=pc_in; simultaneous start uses new pc in FETCH.
REQ-028 FETCH ignores pc_load; pc stable for whole memory access.
REQ-029 pc_in[1:0] SHALL be forced to 2'b00 on load (word alignment).
REQ-030 ERROR: mem_rd=0, ir_valid=0, fetch_err=1; all inputs except reset ignored.
REQ-031 ir6_0 SHALL always equal instr[6:0] (registered together, no extra delay).
REQ-032 instr retains last value outside capture; never cleared by consume.

Reset
REQ-033 reset=0 at rising clk: state<=IDLE, pc<=RESET_PC, instr<=0, ir6_0<=0, counter<=0, ir_valid=0, mem_rd=0, fetch_err=0.
REQ-034 Reset SHALL override all inputs in every state, including mid-FETCH and ERROR; pending memory data discarded.
REQ-035 First cycle after reset release SHALL be IDLE; start in that cycle honored.

Verification
REQ-036 Reset, start=1, mem_ready=1 first FETCH cycle, mem_rdata=32'h00A00093 -> next cycle ir_valid=1, instr=32'h00A00093, ir6_0=7'd19, pc=0.
REQ-037 HOLD, consume=1 -> pc=4, mem_rd=1 next cycle; mem_rdata=32'h123450B7 with ready after 3 wait cycles -> ir6_0=7'd55, ir_valid=1.
REQ-038 FETCH with mem_ready=0 for TIMEOUT cycles -> fetch_err=1, mem_rd=0; later mem_ready=1 -> no change; reset=0 -> fetch_err=0, pc=RESET_PC.
REQ-039 HOLD, consume=1, pc_load=1, pc_in=64'h103 -> pc=64'h100, FETCH addresses 64'h100.
REQ-040 pc=64'hFFFF_FFFF_FFFF_FFFC in HOLD, consume=1 -> pc=0; separately reset=0 mid-FETCH -> IDLE, instr=0, mem_rd=0 next cycle.
